// File: rtl/priority_decoder_stream.sv
// priority_decoder_stream: streaming binary-to-one-hot decoder behind a 2-entry skid buffer.
// Define PRIORITY_DECODER_STATS_EN to build the saturating accepted-word counter on acc_count.
module priority_decoder_stream #(
    parameter  int IN_W  = 3,
    parameter  int CNT_W = 16,
    localparam int OUT_W = 2 ** IN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    input  logic             in_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot,
    output logic [CNT_W-1:0] acc_count
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t           state_q, state_d;
    logic [OUT_W-1:0] head_q, head_d, skid_q, skid_d, dec;
    logic             in_ready_q, accept, pop;
    assign dec        = in_en ? OUT_W'(1) << in_code : '0;
    assign accept     = in_valid && in_ready_q;
    assign pop        = out_valid && out_ready;
    assign in_ready   = in_ready_q;
    assign out_valid  = state_q != EMPTY;
    assign out_onehot = head_q;
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: if (accept) begin
                state_d = ONE;
                head_d  = dec;
            end
            ONE: if (accept && pop) begin
                head_d = dec;
            end else if (accept) begin
                state_d = FULL;
                skid_d  = dec;
            end else if (pop) begin
                state_d = EMPTY;
                head_d  = '0;
            end
            FULL: if (pop) begin
                state_d = ONE;
                head_d  = skid_q;
                skid_d  = '0;
            end
            default: begin
                state_d = EMPTY;
                head_d  = '0;
                skid_d  = '0;
            end
        endcase
    end
    // in_ready is registered from the next occupancy, so it is 0 throughout FULL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= state_d != FULL;
        end
    end
`ifdef PRIORITY_DECODER_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign cnt_d     = (accept && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    assign acc_count = cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign acc_count = '0;
`endif
endmodule

// File: tb/tb_priority_decoder_stream.sv
// tb_priority_decoder_stream: table-driven vectors plus hand sequences, checked through a scoreboard queue.
module tb_priority_decoder_stream;
    logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_en = 1'b0, out_ready = 1'b0;
    logic [2:0] in_code = '0;
    logic       in_ready, out_valid;
    logic [7:0] out_onehot;
    logic [3:0] acc_count;
    int         n_checks = 0, n_fail = 0, acc_model = 0, pop_cnt = 0, pops0;
    logic [7:0] exp_in = '0;
    logic       last_acc = 1'b0;
    logic [7:0] sb[$];
    typedef struct {
        logic [2:0] code;
        logic       en;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[10];

    priority_decoder_stream #(.IN_W(3), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .in_en(in_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_onehot(out_onehot), .acc_count(acc_count)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [3:0] acc_exp();
`ifdef PRIORITY_DECODER_STATS_EN
        return acc_model > 15 ? 4'd15 : 4'(acc_model);
`else
        return 4'd0;
`endif
    endfunction

    // One clock cycle: score pops and accepts seen before the edge, then advance to edge+1.
    task automatic cyc();
        #1;
        if (out_valid && out_ready) begin
            pop_cnt++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL word: got %0h, expected no word", out_onehot);
            end else check("word", out_onehot, sb.pop_front());
        end
        if (!out_valid) check("idle_zero", out_onehot, 0);
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            sb.push_back(exp_in);
            acc_model++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] code, input logic en, input logic [7:0] exp);
        in_valid = 1'b1;
        in_code  = code;
        in_en    = en;
        exp_in   = exp;
        last_acc = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (last_acc) break;
        end
        if (!last_acc) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) vecs[i] = '{3'(i), 1'b1, 8'h01 << i};
        vecs[8] = '{3'd3, 1'b0, 8'h00};
        vecs[9] = '{3'd6, 1'b1, 8'h40};
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_onehot", out_onehot, 0);
        check("rst_count", acc_count, 0);
        rst_n = 1'b1;
        #1;
        check("release_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        check("release_in_ready_high", in_ready, 1);
        out_ready = 1'b1;
        send(3'd5, 1'b1, 8'h20);
        check("t1_valid", out_valid, 1);
        check("t1_onehot", out_onehot, 8'h20);
        pops0 = pop_cnt;
        for (int i = 0; i < 8; i++) send(vecs[i].code, vecs[i].en, vecs[i].exp);
        check("sweep_no_bubble", pop_cnt - pops0, 8);
        check("sweep_last", out_onehot, 8'h80);
        send(vecs[8].code, vecs[8].en, vecs[8].exp);
        check("en0_valid", out_valid, 1);
        check("en0_onehot", out_onehot, 8'h00);
        check("en0_count", acc_count, acc_exp());
        send(vecs[9].code, vecs[9].en, vecs[9].exp);
        repeat (2) cyc();
        check("drain_empty", out_valid, 0);
        // back-pressure: fill to FULL, offer a third word, then release
        out_ready = 1'b0;
        in_valid = 1'b1; in_en = 1'b1; in_code = 3'd1; exp_in = 8'h02;
        cyc();
        check("bp_acc1", last_acc, 1);
        in_code = 3'd2; exp_in = 8'h04;
        cyc();
        check("bp_acc2", last_acc, 1);
        check("bp_ready_low", in_ready, 0);
        check("bp_hold", out_onehot, 8'h02);
        in_code = 3'd6; exp_in = 8'h40;
        cyc();
        check("bp_no_acc", last_acc, 0);
        check("bp_hold2", out_onehot, 8'h02);
        check("bp_valid", out_valid, 1);
        out_ready = 1'b1;
        cyc();
        check("bp_no_acc2", last_acc, 0);
        check("bp_skid_head", out_onehot, 8'h04);
        check("bp_ready_back", in_ready, 1);
        cyc();
        check("bp_reacc", last_acc, 1);
        in_valid = 1'b0;
        check("bp_third", out_onehot, 8'h40);
        cyc();
        check("bp_sb_empty", sb.size(), 0);
        // reset while FULL
        out_ready = 1'b0;
        send(3'd1, 1'b1, 8'h02);
        send(3'd7, 1'b1, 8'h80);
        check("full_ready_low", in_ready, 0);
        check("full_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("async_valid", out_valid, 0);
        check("async_onehot", out_onehot, 0);
        check("async_ready", in_ready, 0);
        check("async_count", acc_count, 0);
        sb.delete();
        acc_model = 0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rerelease_ready", in_ready, 1);
        check("rerelease_valid", out_valid, 0);
        // saturation: 20 accepts
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_code = 3'($urandom_range(0, 7));
            send(in_code, 1'b1, 8'h01 << in_code);
            if (i == 9) check("count_mid", acc_count, acc_exp());
        end
        check("count_sat", acc_count, acc_exp());
        repeat (3) cyc();
        check("count_hold", acc_count, acc_exp());
        check("final_sb_empty", sb.size(), 0);
        check("final_idle", out_valid, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
